hs_parallel_master: RTL and testbench

Bus-side initiator for the handshake parallel I/O interface. It turns a single-cycle host request (read byte / write byte) into the interface's bus protocol. To do so it polls the interface status register over s_/a0/ior_ until the relevant flag is set, then performs the data access over ior_/iow_ and d7_d0. It sits between a simple host (test sequencer or small controller) and the parallel interface, replacing hand-written strobe sequences.

---
 rtl/hs_parallel_master.sv | 157 +++++++++++++++
 tb/tb_hs_parallel_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_parallel_master.sv
// Bus-side initiator for the handshake parallel I/O interface: polls the status register, then moves one byte.
// Optional poll timeout (MAX_POLLS, err) is compiled in with `define HS_MASTER_TIMEOUT_EN.
module hs_parallel_master #(
  parameter int STROBE_CYCLES = 3,
  parameter int GAP_CYCLES    = 2
`ifdef HS_MASTER_TIMEOUT_EN
  ,
  parameter int MAX_POLLS     = 255
`endif
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       req,
  input  logic       op,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] status,
  output logic       s_,
  output logic       a0,
  output logic       ior_,
  output logic       iow_,
  inout  wire  [7:0] d7_d0
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] POLL     = 3'd1;
  localparam logic [2:0] POLL_GAP = 3'd2;
  localparam logic [2:0] XFER     = 3'd3;
  localparam logic [2:0] XFER_GAP = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  // Within an access: cnt 0 = ADDR, 1..STROBE_CYCLES = STROBE, STROBE_CYCLES+1 = RELEASE.
  localparam logic [8:0] STROBE_END = 9'(STROBE_CYCLES);
  localparam logic [8:0] RELEASE_AT = 9'(STROBE_CYCLES + 1);
  localparam logic [8:0] GAP_END    = 9'(GAP_CYCLES - 1);

  logic [2:0] state;
  logic [8:0] cnt;
  logic       op_q;
  logic [7:0] wdata_q;
  logic       flag;
  logic       in_access;
  logic       strobe_on;
  logic       drive_bus;

`ifdef HS_MASTER_TIMEOUT_EN
  logic [7:0] poll_cnt;
  logic       err_q;
`endif

  // Read polls FI (bit 0); write polls FO (bit 1).
  assign flag = op_q ? status[1] : status[0];

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      status  <= '0;
`ifdef HS_MASTER_TIMEOUT_EN
      poll_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state   <= POLL;
            cnt     <= '0;
            op_q    <= op;
            wdata_q <= wdata;
`ifdef HS_MASTER_TIMEOUT_EN
            poll_cnt <= '0;
            err_q    <= 1'b0;
`endif
          end
        end

        POLL, XFER: begin
          // NOTE: the bus is sampled on the edge that ends the last strobe cycle, while ior_ is still low.
          if (cnt == STROBE_END) begin
            if (state == POLL)
              status <= d7_d0;
            else if (!op_q)
              rdata <= d7_d0;
          end
          if (cnt == RELEASE_AT) begin
            cnt   <= '0;
            state <= (state == POLL) ? POLL_GAP : XFER_GAP;
`ifdef HS_MASTER_TIMEOUT_EN
            if (state == POLL)
              poll_cnt <= poll_cnt + 8'd1;
`endif
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        POLL_GAP: begin
          if (cnt == GAP_END) begin
            cnt <= '0;
            if (flag)
              state <= XFER;
`ifdef HS_MASTER_TIMEOUT_EN
            else if (poll_cnt == 8'(MAX_POLLS)) begin
              state <= DONE;
              err_q <= 1'b1;
            end
`endif
            else
              state <= POLL;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        XFER_GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every bus output is a decode of registered state, so a reset edge returns them all to idle at once.
  assign in_access = (state == POLL) || (state == XFER);
  assign strobe_on = in_access && (cnt != 9'd0) && (cnt <= STROBE_END);
  assign drive_bus = (state == XFER) && op_q;

  assign s_    = !in_access;
  assign a0    = (state != POLL);
  assign ior_  = !(strobe_on && !drive_bus);
  assign iow_  = !(strobe_on && drive_bus);
  assign d7_d0 = drive_bus ? wdata_q : 8'hzz;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef HS_MASTER_TIMEOUT_EN
  assign err = done && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_parallel_master.sv
// Self-checking bench for hs_parallel_master: vector table, hand sequences, randomized transfers vs. a latency/count model.
// With HS_MASTER_TIMEOUT_EN defined the DUT is built with MAX_POLLS = 4 and the timeout sequences run.
module tb_hs_parallel_master;

  localparam int S = 3;
  localparam int G = 2;
`ifdef HS_MASTER_TIMEOUT_EN
  localparam int MAX_POLLS  = 4;
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam int MAX_POLLS  = 0;
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clock  = 1'b0;
  logic       reset_ = 1'b0;
  logic       req    = 1'b0;
  logic       op     = 1'b0;
  logic [7:0] wdata  = 8'h00;
  wire  [7:0] rdata;
  wire  [7:0] status;
  wire        busy, done, err, s_, a0, ior_, iow_;
  wire  [7:0] d7_d0;

  int n_checks = 0;
  int n_errs   = 0;

  // Interface model state (written by the stimulus process only).
  int         n_fail_cfg = 0;
  int         poll_base  = 0;
  logic [7:0] st_fail_m  = 8'h00;
  logic [7:0] st_ok_m    = 8'h00;
  logic [7:0] data_m     = 8'h00;
  logic       cur_op     = 1'b0;
  logic [7:0] cur_wdata  = 8'h00;
  bit         skip_len   = 1'b0;

  // Monitor state (written by the monitor process only).
  int   polls_total = 0;
  int   rd_total    = 0;
  int   wr_total    = 0;
  int   run_len     = 0;
  logic prev_ior    = 1'b1;
  logic prev_iow    = 1'b1;
  logic prev_a0     = 1'b1;

  always #5 clock = ~clock;

  hs_parallel_master #(
    .STROBE_CYCLES(S),
    .GAP_CYCLES   (G)
`ifdef HS_MASTER_TIMEOUT_EN
    ,
    .MAX_POLLS    (MAX_POLLS)
`endif
  ) dut (
    .clock (clock),
    .reset_(reset_),
    .req   (req),
    .op    (op),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .status(status),
    .s_    (s_),
    .a0    (a0),
    .ior_  (ior_),
    .iow_  (iow_),
    .d7_d0 (d7_d0)
  );

  // Interface side: answers reads; status reports "not ready" for the first n_fail_cfg polls.
  assign d7_d0 = !ior_ ? (!a0 ? (((polls_total - poll_base) <= n_fail_cfg) ? st_fail_m : st_ok_m)
                              : data_m)
                       : 8'hzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus-rule checker and access counter, sampled mid-cycle.
  always @(negedge clock) begin
    check("strobes_exclusive", {31'd0, !(!ior_ && !iow_)}, 32'd1);
    if ((!ior_ || !iow_) && (!prev_ior || !prev_iow))
      check("a0_stable_in_strobe", {31'd0, a0}, {31'd0, prev_a0});
    if (ior_ && !(!s_ && a0 && cur_op))
      check("bus_released", {31'd0, d7_d0 === 8'hzz}, 32'd1);
    if (!s_ && a0 && cur_op)
      check("write_data_on_bus", {24'd0, d7_d0}, {24'd0, cur_wdata});
    if (!ior_ && prev_ior) begin
      if (!a0) polls_total++;
      else     rd_total++;
    end
    if (!iow_ && prev_iow) wr_total++;
    if (!ior_ || !iow_) begin
      run_len++;
    end else if (run_len != 0) begin
      if (!skip_len) check("strobe_length", run_len, S);
      run_len = 0;
    end
    prev_ior = ior_;
    prev_iow = iow_;
    prev_a0  = a0;
  end

  // Reference model: each poll costs an access plus a gap, the data access the same, then one DONE cycle.
  function automatic void model(input int nf, output int lat, output int np, output int nx,
                                output bit e);
    if (TIMEOUT_EN && nf >= MAX_POLLS) begin
      np  = MAX_POLLS;
      nx  = 0;
      e   = 1'b1;
      lat = MAX_POLLS * (S + 2 + G) + 1;
    end else begin
      np  = nf + 1;
      nx  = 1;
      e   = 1'b0;
      lat = np * (S + 2 + G) + (S + 2 + G) + 1;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
  task automatic run_xfer(input string tag, input bit wr, input logic [7:0] wd, input int nf,
                          input logic [7:0] sf, input logic [7:0] so, input logic [7:0] dat,
                          input int stray_at, input int exp_lat, input int exp_polls,
                          input int exp_rd, input int exp_wr, input bit exp_err,
                          input logic [7:0] exp_rdata, input logic [7:0] exp_status);
    int  k, done_at, p0, r0, w0;
    bit  busy_ok, err_stray, err_at_done;
    n_fail_cfg = nf;
    st_fail_m  = sf;
    st_ok_m    = so;
    data_m     = dat;
    poll_base  = polls_total;
    p0 = polls_total;
    r0 = rd_total;
    w0 = wr_total;
    cur_op    = wr;
    cur_wdata = wd;
    req   = 1'b1;
    op    = wr;
    wdata = wd;
    @(posedge clock);
    @(negedge clock);
    req   = 1'b0;
    op    = 1'($urandom);
    wdata = 8'($urandom);
    k = 1; done_at = 0; busy_ok = 1'b1; err_stray = 1'b0; err_at_done = 1'b0;
    while (done_at == 0 && k <= exp_lat + 20) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_at     = k;
        err_at_done = err;
      end else if (err) begin
        err_stray = 1'b1;
      end
      if (k == stray_at) begin
        req = 1'b1;
        op  = !wr;
      end else if (k == stray_at + 1) begin
        req = 1'b0;
      end
      if (done_at == 0) begin
        @(negedge clock);
        k++;
      end
    end
    req = 1'b0;
    check({tag, " done_cycle"}, done_at, exp_lat);
    check({tag, " busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " err_at_done"}, {31'd0, err_at_done}, {31'd0, exp_err});
    check({tag, " err_outside_done"}, {31'd0, err_stray}, 32'd0);
    check({tag, " rdata"}, {24'd0, rdata}, {24'd0, exp_rdata});
    check({tag, " status"}, {24'd0, status}, {24'd0, exp_status});
    check({tag, " polls"}, polls_total - p0, exp_polls);
    check({tag, " read_xfers"}, rd_total - r0, exp_rd);
    check({tag, " write_xfers"}, wr_total - w0, exp_wr);
    @(negedge clock);
    check({tag, " busy_after_done"}, {30'd0, busy, done}, 32'd0);
    check({tag, " s_after_done"}, {31'd0, s_}, 32'd1);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] wd;
    int         nf;
    logic [7:0] st_fail;
    logic [7:0] st_ok;
    logic [7:0] data;
    int         lat;
    logic [7:0] rdata_exp;
    logic [7:0] status_exp;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_rdata_q;

  initial begin
    int         lat, np, nx, busy_cnt;
    bit         e, wr;
    int         nf;
    logic [7:0] mask, sf, so, dat, wd, exp_st;

    vecs[0] = '{1'b0, 8'h00, 0, 8'h00, 8'h01, 8'hF4, 15, 8'hF4, 8'h01};
    vecs[1] = '{1'b1, 8'hF5, 2, 8'h00, 8'h02, 8'h00, 29, 8'hF4, 8'h02};
    vecs[2] = '{1'b0, 8'h00, 1, 8'hFE, 8'h03, 8'h00, 22, 8'h00, 8'h03};
    vecs[3] = '{1'b1, 8'hA5, 0, 8'h00, 8'hFF, 8'h77, 15, 8'h00, 8'hFF};
    vecs[4] = '{1'b1, 8'h3C, 1, 8'h01, 8'h02, 8'h00, 22, 8'h00, 8'h02};
    vecs[5] = '{1'b0, 8'h00, 3, 8'h02, 8'h01, 8'h5A, 36, 8'h5A, 8'h01};

    // Power-on reset and idle outputs.
    repeat (3) @(negedge clock);
    check("reset s_a0_ior_iow_", {28'd0, s_, a0, ior_, iow_}, 32'hF);
    check("reset busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("reset rdata", {24'd0, rdata}, 32'd0);
    check("reset status", {24'd0, status}, 32'd0);
    check("reset bus_z", {31'd0, d7_d0 === 8'hzz}, 32'd1);
    reset_ = 1'b1;
    @(negedge clock);
    exp_rdata_q = 8'h00;

    // Vector table, issued back-to-back.
    for (int i = 0; i < 6; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].wd, vecs[i].nf, vecs[i].st_fail,
               vecs[i].st_ok, vecs[i].data, 0, vecs[i].lat, vecs[i].nf + 1,
               vecs[i].wr ? 0 : 1, vecs[i].wr ? 1 : 0, 1'b0, vecs[i].rdata_exp,
               vecs[i].status_exp);
      exp_rdata_q = vecs[i].rdata_exp;
    end

    // req pulsed while busy must be dropped, not queued.
    run_xfer("stray_req", 1'b0, 8'h00, 0, 8'h00, 8'h01, 8'h9C, 5, 15, 1, 1, 0, 1'b0, 8'h9C, 8'h01);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || !s_) busy_cnt++;
      @(negedge clock);
    end
    check("stray_req not_queued", busy_cnt, 0);

    // Two transfers with the second req in the cycle right after done.
    run_xfer("b2b_a", 1'b1, 8'h66, 0, 8'h00, 8'h02, 8'h00, 0, 15, 1, 0, 1, 1'b0, 8'h9C, 8'h02);
    run_xfer("b2b_b", 1'b0, 8'h00, 0, 8'h00, 8'h01, 8'hC3, 0, 15, 1, 1, 0, 1'b0, 8'hC3, 8'h01);
    exp_rdata_q = 8'hC3;

    // Reset in the middle of a poll strobe.
    n_fail_cfg = 1000;
    st_fail_m  = 8'h00;
    poll_base  = polls_total;
    cur_op     = 1'b0;
    req = 1'b1;
    op  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    check("midreset in_strobe", {31'd0, ior_}, 32'd0);
    skip_len = 1'b1;
    reset_   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    check("midreset strobes_s_a0", {28'd0, s_, a0, ior_, iow_}, 32'hF);
    check("midreset busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("midreset rdata", {24'd0, rdata}, 32'd0);
    check("midreset status", {24'd0, status}, 32'd0);
    check("midreset bus_z", {31'd0, d7_d0 === 8'hzz}, 32'd1);
    @(negedge clock);
    skip_len = 1'b0;
    check("midreset stays_idle", {31'd0, busy}, 32'd0);
    exp_rdata_q = 8'h00;

    // Randomized transfers against the model.
    for (int i = 0; i < 30; i++) begin
      wr   = 1'($urandom);
      nf   = $urandom_range(0, 5);
      mask = wr ? 8'h02 : 8'h01;
      sf   = 8'($urandom) & ~mask;
      so   = 8'($urandom) | mask;
      dat  = 8'($urandom);
      wd   = 8'($urandom);
      model(nf, lat, np, nx, e);
      exp_st = e ? sf : so;
      if (!wr && !e) exp_rdata_q = dat;
      run_xfer($sformatf("rand%0d", i), wr, wd, nf, sf, so, dat, 0, lat, np,
               wr ? 0 : nx, wr ? nx : 0, e, exp_rdata_q, exp_st);
    end

`ifdef HS_MASTER_TIMEOUT_EN
    // Status stuck clear: exactly MAX_POLLS polls, no data access, err with done.
    run_xfer("timeout_rd", 1'b0, 8'h00, 100, 8'h00, 8'h01, 8'hEE, 0, 29, 4, 0, 0, 1'b1,
             exp_rdata_q, 8'h00);
    run_xfer("timeout_wr", 1'b1, 8'h81, 100, 8'h00, 8'h02, 8'h00, 0, 29, 4, 0, 0, 1'b1,
             exp_rdata_q, 8'h00);
    run_xfer("after_timeout", 1'b0, 8'h00, 0, 8'h00, 8'h01, 8'h42, 0, 15, 1, 1, 0, 1'b0,
             8'h42, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
